// File: rtl/parity_gen_chk.sv
// Lane parity generator / checker with a 2-entry output FIFO.
// Each beat is either tagged with freshly generated lane parity or checked
// against received parity. The result is buffered with full-throughput
// valid/ready handshakes on both sides.
// Optional feature: define PARITY_ERR_CNT_EN to add the saturating err_cnt
// port and its counter.
// DATA_W must be a multiple of LANE_W.
module parity_gen_chk #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned ODD    = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mode_chk,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [DATA_W/LANE_W-1:0]   in_par,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [DATA_W/LANE_W-1:0]   out_par,
  output logic                       out_err,
  input  logic                       err_clr,
  output logic                       err_sticky
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [15:0]                err_cnt
`endif
);

  localparam int unsigned NLANES = DATA_W / LANE_W;
  localparam bit          OddBit = (ODD != 0);

  logic [NLANES-1:0] calc_par;
  logic [NLANES-1:0] beat_par;
  logic              beat_err;
  logic              push;
  logic              pop;
  logic              acc_err;

  logic [DATA_W-1:0] data_q [2];
  logic [NLANES-1:0] par_q  [2];
  logic              err_q  [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              in_ready_q;
  logic              err_sticky_q, err_sticky_d;

  // Per-lane parity and the per-beat result that gets buffered.
  always_comb begin
    calc_par = '0;
    for (int k = 0; k < NLANES; k++) begin
      calc_par[k] = (^in_data[k*LANE_W +: LANE_W]) ^ OddBit;
    end
    beat_par = mode_chk ? in_par : calc_par;
    beat_err = mode_chk & (|(calc_par ^ in_par));
  end

  assign push    = in_valid & in_ready_q;
  assign pop     = out_valid & out_ready;
  assign acc_err = push & beat_err;

  // Occupancy and sticky-error next state; sticky set wins over clear.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
    err_sticky_d = (err_sticky_q & ~err_clr) | acc_err;
  end

  // FIFO storage, pointers, registered in_ready and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        par_q[i]  <= '0;
        err_q[i]  <= 1'b0;
      end
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      in_ready_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        par_q[wr_ptr_q]  <= beat_par;
        err_q[wr_ptr_q]  <= beat_err;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q        <= cnt_d;
      // Registered from next occupancy so it never depends on same-cycle out_ready.
      in_ready_q   <= (cnt_d < 2'd2);
      err_sticky_q <= err_sticky_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = data_q[rd_ptr_q];
  assign out_par    = par_q[rd_ptr_q];
  assign out_err    = err_q[rd_ptr_q];
  assign err_sticky = err_sticky_q;

`ifdef PARITY_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating errored-beat counter; a clear coinciding with an error leaves 1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = acc_err ? 16'd1 : 16'd0;
    end else if (acc_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_gen_chk.sv
// Directed self-checking bench for parity_gen_chk (even and odd instances).
module tb_parity_gen_chk;

  logic        clk = 1'b0;
  logic        reset_n;

  // Even-parity instance.
  logic        mode_chk, in_valid, in_ready, out_valid, out_ready, out_err, err_clr, err_sticky;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_par, out_par;

  // Odd-parity instance.
  logic        o_mode_chk, o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_out_err;
  logic        o_err_clr, o_err_sticky;
  logic [31:0] o_in_data, o_out_data;
  logic [3:0]  o_in_par, o_out_par;

`ifdef PARITY_ERR_CNT_EN
  logic [15:0] err_cnt, o_err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parity_gen_chk #(.DATA_W(32), .LANE_W(8), .ODD(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode_chk   (mode_chk),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_par    (out_par),
    .out_err    (out_err),
    .err_clr    (err_clr),
    .err_sticky (err_sticky)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  parity_gen_chk #(.DATA_W(32), .LANE_W(8), .ODD(1)) dut_odd (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode_chk   (o_mode_chk),
    .in_valid   (o_in_valid),
    .in_ready   (o_in_ready),
    .in_data    (o_in_data),
    .in_par     (o_in_par),
    .out_valid  (o_out_valid),
    .out_ready  (o_out_ready),
    .out_data   (o_out_data),
    .out_par    (o_out_par),
    .out_err    (o_out_err),
    .err_clr    (o_err_clr),
    .err_sticky (o_err_sticky)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (o_err_cnt)
`endif
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    mode_chk = 0; in_valid = 0; out_ready = 1; in_data = '0; in_par = '0; err_clr = 0;
    o_mode_chk = 0; o_in_valid = 0; o_out_ready = 1; o_in_data = '0; o_in_par = '0;
    o_err_clr = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_par !== 4'h0 ||
        out_err !== 1'b0 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b d=%h p=%h e=%b s=%b want all zero",
               out_valid, in_ready, out_data, out_par, out_err, err_sticky);
    end
`ifdef PARITY_ERR_CNT_EN
    n_tests++;
    if (err_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %h want 0000", err_cnt);
    end
`endif
    reset_n = 1'b1;
    step();
    n_tests++;
    if (in_ready !== 1'b1 || o_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b/%b want 1/1", in_ready, o_in_ready);
    end
  endtask

  task automatic test_generate;
    logic [31:0] vd [3] = '{32'h0103_0700, 32'hFFFF_FFFF, 32'h8000_0001};
    logic [3:0]  vp [3] = '{4'b1010, 4'b0000, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      mode_chk = 0; in_valid = 1; in_data = vd[i]; in_par = 4'hF; out_ready = 1;
      step();
      in_valid = 0;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== vd[i] || out_par !== vp[i] || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL gen_%0d: got v=%b d=%h p=%b e=%b want v=1 d=%h p=%b e=0",
                 i, out_valid, out_data, out_par, out_err, vd[i], vp[i]);
      end
      step();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL gen_retire_%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
    // Even instance check mode: matching then mismatching parity.
    mode_chk = 1; in_valid = 1; in_data = 32'h0103_0700; in_par = 4'b1010;
    step();
    in_valid = 0;
    n_tests++;
    if (out_err !== 1'b0 || out_par !== 4'b1010 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL chk_even_ok: got e=%b p=%b s=%b want 0 1010 0",
                         out_err, out_par, err_sticky);
    end
    in_valid = 1; in_par = 4'b1011;
    step();
    in_valid = 0; mode_chk = 0;
    n_tests++;
    if (out_err !== 1'b1 || out_par !== 4'b1011 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL chk_even_bad: got e=%b p=%b s=%b want 1 1011 1",
                         out_err, out_par, err_sticky);
    end
    err_clr = 1;
    step();
    err_clr = 0;
  endtask

  task automatic test_check_odd;
    o_err_clr = 1;
    step();
    o_err_clr = 0;
    o_mode_chk = 1; o_in_valid = 1; o_in_data = 32'h0000_00FF; o_in_par = 4'b1110;
    step();
    n_tests++;
    if (o_out_valid !== 1'b1 || o_out_err !== 1'b1 || o_out_par !== 4'b1110 ||
        o_err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL chk_odd_bad: got v=%b e=%b p=%b s=%b want 1 1 1110 1",
                         o_out_valid, o_out_err, o_out_par, o_err_sticky);
    end
`ifdef PARITY_ERR_CNT_EN
    n_tests++;
    if (o_err_cnt !== 16'd1) begin
      n_fail++; $display("FAIL chk_odd_cnt: got %0d want 1", o_err_cnt);
    end
`endif
    o_in_par = 4'b1111;
    step();
    o_in_valid = 0;
    n_tests++;
    if (o_out_valid !== 1'b1 || o_out_err !== 1'b0 || o_out_par !== 4'b1111 ||
        o_err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL chk_odd_ok: got v=%b e=%b p=%b s=%b want 1 0 1111 1",
                         o_out_valid, o_out_err, o_out_par, o_err_sticky);
    end
    o_err_clr = 1;
    step();
    n_tests++;
    if (o_err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clr: got %b want 0", o_err_sticky);
    end
    o_in_valid = 1; o_in_par = 4'b1110;
    step();
    o_in_valid = 0; o_err_clr = 0;
    n_tests++;
    if (o_err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set_clr: got %b want 1", o_err_sticky);
    end
`ifdef PARITY_ERR_CNT_EN
    n_tests++;
    if (o_err_cnt !== 16'd1) begin
      n_fail++; $display("FAIL cnt_set_clr: got %0d want 1", o_err_cnt);
    end
`endif
    step();
  endtask

  task automatic test_back_to_back;
    mode_chk = 0; out_ready = 0;
    in_valid = 1; in_data = 32'hAAAA_0001;
    step();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_occ1: got %b want 1", in_ready);
    end
    in_data = 32'hBBBB_0002;
    step();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_full: got %b want 0", in_ready);
    end
    in_data = 32'hCCCC_0003;
    step();
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL b2b_stall: got rdy=%b v=%b d=%h want 0 1 aaaa0001",
                         in_ready, out_valid, out_data);
    end
    out_ready = 1;
    step();
    n_tests++;
    if (in_ready !== 1'b1 || out_data !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL b2b_B: got rdy=%b d=%h want 1 bbbb0002", in_ready, out_data);
    end
    step();
    in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hCCCC_0003) begin
      n_fail++; $display("FAIL b2b_C: got v=%b d=%h want 1 cccc0003", out_valid, out_data);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stream;
    int errs = 0;
    mode_chk = 0; out_ready = 1; in_valid = 1;
    for (int i = 0; i < 100; i++) begin
      in_data = 32'h1000_0000 + i;
      step();
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h1000_0000 + i) begin
        errs++;
        if (errs <= 3) begin
          $display("FAIL stream_%0d: got rdy=%b v=%b d=%h want 1 1 %h",
                   i, in_ready, out_valid, out_data, 32'h1000_0000 + i);
        end
      end
    end
    in_valid = 0;
    n_tests++;
    if (errs != 0) n_fail++;
    step();
  endtask

  task automatic test_reset_mid;
    out_ready = 0; in_valid = 1; mode_chk = 0;
    in_data = 32'hDEAD_0001;
    step();
    in_data = 32'hDEAD_0002;
    step();
    in_valid = 0;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got v=%b rdy=%b d=%h want 0 0 0",
                         out_valid, in_ready, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1;
    step();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    in_valid = 1; in_data = 32'h5555_AAAA;
    step();
    in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL reset_mid_fresh: got v=%b d=%h want 1 5555aaaa",
                         out_valid, out_data);
    end
    step();
  endtask

`ifdef PARITY_ERR_CNT_EN
  task automatic test_err_cnt;
    o_err_clr = 1;
    step();
    o_err_clr = 0;
    o_out_ready = 1; o_mode_chk = 1; o_in_data = 32'h0000_00FF; o_in_par = 4'b0000;
    o_in_valid = 1;
    repeat (65537) @(posedge clk);
    @(negedge clk);
    o_in_valid = 0;
    n_tests++;
    if (o_err_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL cnt_saturate: got %h want ffff", o_err_cnt);
    end
    o_in_valid = 1; o_err_clr = 1;
    step();
    o_in_valid = 0; o_err_clr = 0;
    n_tests++;
    if (o_err_cnt !== 16'd1) begin
      n_fail++; $display("FAIL cnt_clr_inc: got %h want 0001", o_err_cnt);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_generate();
    test_check_odd();
    test_back_to_back();
    test_stream();
    test_reset_mid();
`ifdef PARITY_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
